// File: rtl/usb_stuff_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_stuff_serializer_pkg
// Description : Shared types and USB framing constants for the TX serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_stuff_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STUFF = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_e;

    localparam logic [7:0] c_SYNC      = 8'b0000_0001;
    localparam logic [3:0] c_PID_OUT   = 4'b0001;
    localparam logic [3:0] c_PID_IN    = 4'b1001;
    localparam logic [3:0] c_PID_SETUP = 4'b1101;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_DATA1 = 4'b1011;
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;

    // Packet sizes in bits including sync and PID.
    localparam int c_TOK_BITS      = 32;
    localparam int c_HS_BITS       = 16;
    localparam int c_DATA_MAX_BITS = 99;

    // PID byte carries its own one's-complement check nibble.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_stuff_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_stuff_serializer_if
// Description : Packet handshake and line-side signals of the TX serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_stuff_serializer_if #(
    parameter int MAX_W = 99,
    parameter int LEN_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [MAX_W-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             abort;
    logic             out_bit;
    logic             out_valid;
    logic             done;

    modport master (
        output in_valid, in_data, in_len, abort,
        input  in_ready, out_bit, out_valid, done
    );

    modport slave (
        input  in_valid, in_data, in_len, abort,
        output in_ready, out_bit, out_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/usb_stuff_serializer_nrzi.sv
`default_nettype none
// ============================================================================
// Module      : usb_nrzi_enc
// Description : NRZI line encoder; holds the line level between bits.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_nrzi_enc #(
    parameter bit NRZI_EN = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic raw_i,
    input  wire logic clr_i,
    output logic      line_o
);
    logic nrzi_q;
    logic nrzi_d;
    logic w_enc;

    always_comb begin
        w_enc  = NRZI_EN ? (raw_i ? nrzi_q : ~nrzi_q) : raw_i;
        line_o = en_i ? w_enc : 1'b0;
        nrzi_d = nrzi_q;
        // Clearing wins so an aborted bit never leaks into the next packet.
        if (clr_i) begin
            nrzi_d = 1'b1;
        end else if (en_i) begin
            nrzi_d = w_enc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrzi_q <= 1'b1;
        end else begin
            nrzi_q <= nrzi_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/usb_stuff_serializer.sv
`default_nettype none
// ============================================================================
// Module      : usb_stuff_serializer
// Description : Variable-length packet serializer with bit stuffing and NRZI.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_stuff_serializer
    import usb_stuff_serializer_pkg::*;
#(
    parameter int MAX_W     = 99,
    parameter int LEN_W     = 7,
    parameter bit STUFF_EN  = 1'b1,
    parameter int STUFF_RUN = 6,
    parameter bit NRZI_EN   = 1'b1
) (
    input wire logic             clk,
    input wire logic             rst,
    usb_stuff_serializer_if.slave tx
);
    localparam int               ONES_W     = $clog2(STUFF_RUN + 1);
    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_W);
    localparam logic [ONES_W-1:0] c_RUN_LAST = ONES_W'(STUFF_RUN - 1);
    localparam logic [ONES_W-1:0] c_ONES_MAX = '1;

    tx_state_e          state_q, state_d;
    logic [MAX_W-1:0]   data_q,  data_d;
    logic [LEN_W-1:0]   idx_q,   idx_d;
    logic [ONES_W-1:0]  ones_q,  ones_d;
    logic               last_q,  last_d;

    logic [LEN_W-1:0]   w_len;
    logic               w_raw;
    logic               w_out_valid;
    logic               w_nrzi_clr;
    logic               w_line;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        last_d  = last_q;
        w_raw   = 1'b0;
        w_len   = (tx.in_len > c_MAX_LEN) ? c_MAX_LEN : tx.in_len;

        case (state_q)
            ST_IDLE: begin
                if (tx.in_valid) begin
                    data_d = tx.in_data;
                    ones_d = '0;
                    last_d = 1'b0;
                    if (w_len == '0) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = w_len - LEN_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                w_raw  = data_q[idx_q];
                ones_d = w_raw ? ((ones_q == c_ONES_MAX) ? ones_q : ones_q + ONES_W'(1)) : '0;
                // last_q remembers whether the stuff bit closes the packet,
                // since idx alone cannot tell "bit 0 pending" from "bit 0 sent".
                if (STUFF_EN && w_raw && (ones_q == c_RUN_LAST)) begin
                    state_d = ST_STUFF;
                    last_d  = (idx_q == '0);
                    if (idx_q != '0) begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end else if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - LEN_W'(1);
                end
            end
            ST_STUFF: begin
                w_raw   = 1'b0;
                ones_d  = '0;
                state_d = last_q ? ST_DONE : ST_SEND;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            ones_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            last_q  <= last_d;
        end
    end

    assign w_out_valid = (state_q == ST_SEND) || (state_q == ST_STUFF);
    assign w_nrzi_clr  = (state_q == ST_DONE) || (tx.abort && (state_q != ST_IDLE));

    usb_nrzi_enc #(
        .NRZI_EN (NRZI_EN)
    ) u_nrzi (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_out_valid),
        .raw_i  (w_raw),
        .clr_i  (w_nrzi_clr),
        .line_o (w_line)
    );

    assign tx.in_ready  = (state_q == ST_IDLE);
    assign tx.out_valid = w_out_valid;
    assign tx.out_bit   = w_line;
    assign tx.done      = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_usb_stuff_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_stuff_serializer
// Description : Directed bench for the serializer, raw and NRZI builds side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_stuff_serializer;
    localparam int MAX_W = 99;
    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             r_valid;
    logic             r_abort;
    logic [MAX_W-1:0] r_data;
    logic [LEN_W-1:0] r_len;

    always #5 clk = ~clk;

    usb_stuff_serializer_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) if_raw ();
    usb_stuff_serializer_if #(.MAX_W(MAX_W), .LEN_W(LEN_W)) if_nrz ();

    assign if_raw.in_valid = r_valid;
    assign if_raw.in_data  = r_data;
    assign if_raw.in_len   = r_len;
    assign if_raw.abort    = r_abort;
    assign if_nrz.in_valid = r_valid;
    assign if_nrz.in_data  = r_data;
    assign if_nrz.in_len   = r_len;
    assign if_nrz.abort    = r_abort;

    usb_stuff_serializer #(.MAX_W(MAX_W), .LEN_W(LEN_W), .STUFF_EN(1'b1),
                           .STUFF_RUN(6), .NRZI_EN(1'b0))
        u_dut_raw (.clk(clk), .rst(rst), .tx(if_raw));

    usb_stuff_serializer #(.MAX_W(MAX_W), .LEN_W(LEN_W), .STUFF_EN(1'b1),
                           .STUFF_RUN(6), .NRZI_EN(1'b1))
        u_dut_nrz (.clk(clk), .rst(rst), .tx(if_nrz));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference NRZI of a raw stream, first bit at position n-1, line idles at 1.
    function automatic logic [255:0] nrzi_of(input logic [255:0] raw, input int n);
        logic [255:0] res;
        logic         q;
        res = '0;
        q   = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            res[i] = raw[i] ? q : ~q;
            q      = res[i];
        end
        return res;
    endfunction

    task automatic run_pkt(input logic [MAX_W-1:0] data, input logic [LEN_W-1:0] len,
                           output int n, output logic [255:0] raw_bits,
                           output logic [255:0] line_bits, output int done_at);
        @(negedge clk);
        r_data  = data;
        r_len   = len;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid   = 1'b0;
        n         = 0;
        raw_bits  = '0;
        line_bits = '0;
        done_at   = -1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            if (if_raw.done) begin
                done_at = c;
                break;
            end
            if (if_raw.out_valid) begin
                raw_bits  = {raw_bits[254:0], if_raw.out_bit};
                line_bits = {line_bits[254:0], if_nrz.out_bit};
                n++;
            end
        end
    endtask

    typedef struct {
        string            name;
        logic [MAX_W-1:0] data;
        logic [LEN_W-1:0] len;
        int               n;
        logic [255:0]     bits;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int           n;
        int           done_at;
        logic [255:0] rb;
        logic [255:0] lb;
        logic [19:0]  ov_v;
        logic [19:0]  dn_v;
        logic [19:0]  bt_v;
        int           seen;

        vecs[0] = '{"lsb1",    99'h1,           7'd8,   8,  256'b00000001};
        vecs[1] = '{"ff",      99'hFF,          7'd8,   9,  256'b111111011};
        vecs[2] = '{"six1",    99'h3F,          7'd6,   7,  256'b1111110};
        vecs[3] = '{"len0",    99'hFF,          7'd0,   0,  256'b0};
        vecs[4] = '{"aa",      99'hAA,          7'd8,   8,  256'b10101010};
        vecs[5] = '{"twelve1", 99'hFFF,         7'd12,  14, 256'b11111101111110};
        vecs[6] = '{"run5",    99'b1111101111,  7'd10,  10, 256'b1111101111};
        vecs[7] = '{"clamp",   99'h1,           7'd127, 99, 256'h1};
        vecs[8] = '{"seven",   99'b1111110,     7'd7,   8,  256'b11111100};
        vecs[9] = '{"hi_ign",  99'hFF01,        7'd8,   8,  256'b00000001};

        rst     = 1'b1;
        r_valid = 1'b0;
        r_abort = 1'b0;
        r_data  = '0;
        r_len   = '0;
        #1;
        check("reset_in", {if_raw.in_ready, if_raw.out_valid, if_raw.out_bit, if_raw.done,
                           if_nrz.in_ready, if_nrz.out_valid, if_nrz.out_bit, if_nrz.done},
              8'b1000_1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", {if_raw.in_ready, if_raw.out_valid, if_raw.out_bit, if_raw.done,
                            if_nrz.in_ready, if_nrz.out_valid, if_nrz.out_bit, if_nrz.done},
              8'b1000_1000);

        for (int i = 0; i < 10; i++) begin
            run_pkt(vecs[i].data, vecs[i].len, n, rb, lb, done_at);
            check({vecs[i].name, " count"}, n, vecs[i].n);
            check({vecs[i].name, " raw"}, rb, vecs[i].bits);
            check({vecs[i].name, " nrzi"}, lb, nrzi_of(vecs[i].bits, vecs[i].n));
            check({vecs[i].name, " done_at"}, done_at, vecs[i].n);
            @(negedge clk);
            check({vecs[i].name, " ready_after"}, {if_raw.in_ready, if_raw.done, if_nrz.in_ready},
                  3'b101);
        end

        // NRZI of the sync pattern from idle is KJKJKJKK.
        run_pkt(99'h1, 7'd8, n, rb, lb, done_at);
        check("sync_nrzi", lb, 8'b01010100);

        // Abort on the third bit of a token.
        @(negedge clk);
        r_data  = 99'h01E1_A5C3;
        r_len   = 7'd32;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        seen    = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (if_raw.out_valid) seen++;
        end
        check("abort_reach3", seen, 3);
        r_abort = 1'b1;
        @(negedge clk);
        r_abort = 1'b0;
        check("abort_next", {if_raw.out_valid, if_raw.done, if_raw.in_ready,
                             if_nrz.out_valid, if_nrz.done}, 5'b00100);
        @(negedge clk);
        check("abort_nodone", {if_raw.done, if_nrz.done, if_raw.out_valid}, 3'b000);
        run_pkt(99'h1, 7'd8, n, rb, lb, done_at);
        check("abort_then_nrzi", lb, 8'b01010100);

        // Abort in IDLE together with in_valid: packet is still accepted.
        @(negedge clk);
        r_data  = 99'h1;
        r_len   = 7'd8;
        r_valid = 1'b1;
        r_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        r_abort = 1'b0;
        check("idle_abort_accept", {if_raw.out_valid, if_raw.in_ready}, 2'b10);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if_raw.done) begin
                seen = 1;
                break;
            end
        end
        check("idle_abort_done", seen, 1);

        // Reset in the middle of a 99-bit packet.
        @(negedge clk);
        r_data  = {33{3'b101}};
        r_len   = 7'd99;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {if_raw.out_valid, if_raw.in_ready}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst", {if_raw.in_ready, if_raw.out_valid, if_raw.out_bit, if_raw.done,
                          if_nrz.in_ready, if_nrz.out_valid, if_nrz.out_bit, if_nrz.done},
              8'b1000_1000);
        @(negedge clk);
        rst = 1'b0;
        run_pkt(99'h1, 7'd8, n, rb, lb, done_at);
        check("post_rst_nrzi", lb, 8'b01010100);
        check("post_rst_done", done_at, 8);

        // Back-to-back with in_valid held while busy and data changed.
        @(negedge clk);
        r_data  = 99'h00;
        r_len   = 7'd8;
        r_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_data = 99'hFF;
        ov_v   = '0;
        dn_v   = '0;
        bt_v   = '0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            ov_v = {ov_v[18:0], if_raw.out_valid};
            dn_v = {dn_v[18:0], if_raw.done};
            bt_v = {bt_v[18:0], if_raw.out_bit};
        end
        r_valid = 1'b0;
        check("b2b_valid", ov_v, 20'b11111111_00_111111111_0);
        check("b2b_done",  dn_v, 20'b00000000_10_000000000_1);
        check("b2b_bits",  bt_v, 20'b00000000_00_111111011_0);
        @(negedge clk);
        check("b2b_idle", {if_raw.in_ready, if_raw.out_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
